// File: rtl/cpu_bus_arbiter.sv
// Two-port round-robin arbiter for the external strobe/ready memory bus.
// Runs one transaction at a time; a stalled transfer is aborted by timeout.
module cpu_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_req,
    input  logic [1:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic [1:0]        o_done,
    output logic              o_err,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_owner,
    output logic              o_busy,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t state_q, state_d;

    logic [1:0]        done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              owner_q, owner_d;
    logic              busy_q, busy_d;
    logic              bus_clk_q, bus_clk_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_data_q, bus_data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Port that wins the next tie; flips to the loser on every grant.
    logic              prio_q, prio_d;

    logic win;
    logic timeout_hit;

    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (i_req == 2'b11): win = prio_q;
            (i_req == 2'b10): win = 1'b1;
            default:          win = 1'b0;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    state_d = STROBE;
                end
            end
            STROBE: begin
                if (i_bus_data_ready || timeout_hit) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d     = done_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        owner_d    = owner_q;
        busy_d     = busy_q;
        bus_clk_d  = bus_clk_q;
        bus_we_d   = bus_we_q;
        bus_addr_d = bus_addr_q;
        bus_data_d = bus_data_q;
        cnt_d      = cnt_q;
        prio_d     = prio_q;
        case (state_q)
            IDLE: begin
                if (|i_req) begin
                    bus_clk_d  = 1'b1;
                    busy_d     = 1'b1;
                    owner_d    = win;
                    prio_d     = ~win;
                    cnt_d      = '0;
                    bus_we_d   = i_we[win];
                    bus_addr_d = win ? i_addr1 : i_addr0;
                    bus_data_d = win ? i_wdata1 : i_wdata0;
                end
            end
            STROBE: begin
                if (i_bus_data_ready) begin
                    bus_clk_d = 1'b0;
                    rdata_d   = bus_we_q ? '0 : i_bus_data;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    err_d     = 1'b0;
                end else if (timeout_hit) begin
                    bus_clk_d = 1'b0;
                    rdata_d   = '0;
                    done_d    = owner_q ? 2'b10 : 2'b01;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                done_d   = 2'b00;
                err_d    = 1'b0;
                rdata_d  = '0;
                bus_we_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                bus_clk_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            done_q     <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            owner_q    <= 1'b0;
            busy_q     <= 1'b0;
            bus_clk_q  <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_addr_q <= '0;
            bus_data_q <= '0;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
        end else begin
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
            bus_clk_q  <= bus_clk_d;
            bus_we_q   <= bus_we_d;
            bus_addr_q <= bus_addr_d;
            bus_data_q <= bus_data_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
        end
    end

    assign o_done     = done_q;
    assign o_err      = err_q;
    assign o_rdata    = rdata_q;
    assign o_owner    = owner_q;
    assign o_busy     = busy_q;
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = bus_addr_q;
    assign o_bus_data = bus_data_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios plus random traffic,
// all cycles checked against a transaction-level model.
module tb_cpu_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [1:0]    i_req = 2'b00;
    logic [1:0]    i_we = 2'b00;
    logic [AW-1:0] i_addr0 = '0;
    logic [AW-1:0] i_addr1 = '0;
    logic [DW-1:0] i_wdata0 = '0;
    logic [DW-1:0] i_wdata1 = '0;
    logic [DW-1:0] i_bus_data = '0;
    logic          i_bus_data_ready = 1'b0;
    logic [1:0]    o_done;
    logic          o_err;
    logic [DW-1:0] o_rdata;
    logic          o_owner;
    logic          o_busy;
    logic          o_bus_clk;
    logic          o_bus_we;
    logic [AW-1:0] o_bus_addr;
    logic [DW-1:0] o_bus_data;

    cpu_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_owner(o_owner), .o_busy(o_busy), .o_bus_clk(o_bus_clk),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr),
        .o_bus_data(o_bus_data), .i_bus_data(i_bus_data),
        .i_bus_data_ready(i_bus_data_ready)
    );

    always #5 i_clk = ~i_clk;

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one open transfer record, its age in
    // strobe edges, and whether its completion is being reported.
    bit            m_open = 0;
    bit            m_report = 0;
    bit            m_last = 1;
    bit            m_w = 0;
    int            m_edges = 0;
    logic [1:0]    e_done = 0;
    logic          e_err = 0;
    logic          e_owner = 0;
    logic          e_busy = 0;
    logic          e_bus_clk = 0;
    logic          e_bus_we = 0;
    logic [DW-1:0] e_rdata = 0;
    logic [AW-1:0] e_bus_addr = 0;
    logic [DW-1:0] e_bus_data = 0;

    task automatic m_clear();
        m_open = 0; m_report = 0; m_last = 1; m_edges = 0;
        e_done = 0; e_err = 0; e_owner = 0; e_busy = 0;
        e_bus_clk = 0; e_bus_we = 0; e_rdata = 0;
        e_bus_addr = 0; e_bus_data = 0;
    endtask

    task automatic m_finish(input logic err, input logic [DW-1:0] rd);
        e_bus_clk = 0;
        e_done = 2'b00;
        e_done[e_owner] = 1'b1;
        e_err = err;
        e_rdata = rd;
        m_report = 1;
    endtask

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_clear();
        end else if (m_report) begin
            m_report = 0; m_open = 0;
            e_done = 0; e_err = 0; e_rdata = 0;
            e_bus_we = 0; e_busy = 0;
        end else if (m_open) begin
            m_edges++;
            if (i_bus_data_ready)
                m_finish(1'b0, e_bus_we ? '0 : i_bus_data);
            else if (TO != 0 && m_edges == TO)
                m_finish(1'b1, '0);
        end else if (i_req != 2'b00) begin
            m_w = (i_req == 2'b11) ? !m_last : i_req[1];
            m_last = m_w;
            m_open = 1; m_edges = 0;
            e_owner = m_w; e_busy = 1; e_bus_clk = 1;
            e_bus_we = i_we[m_w];
            e_bus_addr = m_w ? i_addr1 : i_addr0;
            e_bus_data = m_w ? i_wdata1 : i_wdata0;
        end
    end

    task automatic compare_model();
        chk("m_done", o_done, e_done);
        chk("m_err", o_err, e_err);
        chk("m_rdata", o_rdata, e_rdata);
        chk("m_owner", o_owner, e_owner);
        chk("m_busy", o_busy, e_busy);
        chk("m_bus_clk", o_bus_clk, e_bus_clk);
        chk("m_bus_we", o_bus_we, e_bus_we);
        if (e_busy) begin
            chk("m_bus_addr", o_bus_addr, e_bus_addr);
            chk("m_bus_data", o_bus_data, e_bus_data);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (!i_rst) compare_model();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_done != 2'b00) begin
                seen = 1;
                break;
            end
        end
        chk(name, seen, 1);
    endtask

    // Drives one transfer on port p; ready is offered only at strobe
    // edge rdy_edge (0 = never).
    task automatic do_tx(input int p, input bit we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] rd,
                         input int rdy_edge, output int hi,
                         output logic [1:0] dn, output logic er,
                         output logic [DW-1:0] rdv, output logic own,
                         output logic bwe, output logic [AW-1:0] badr,
                         output logic [DW-1:0] bdat);
        hi = 0; dn = 0; er = 0; rdv = 0; own = 0; bwe = 0; badr = 0; bdat = 0;
        if (p == 0) begin
            i_addr0 = addr; i_wdata0 = wdata;
        end else begin
            i_addr1 = addr; i_wdata1 = wdata;
        end
        i_we = 2'b00; i_we[p] = we;
        i_req = 2'b00; i_req[p] = 1'b1;
        i_bus_data = rd; i_bus_data_ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (o_bus_clk) begin
                hi++;
                own = o_owner; bwe = o_bus_we;
                badr = o_bus_addr; bdat = o_bus_data;
            end
            if (o_done != 2'b00) begin
                dn = o_done; er = o_err; rdv = o_rdata;
                break;
            end
            i_bus_data_ready = (rdy_edge != 0) && (k == rdy_edge);
        end
        i_req = 2'b00;
        i_bus_data_ready = 1'b0;
    endtask

    initial begin
        int hi;
        logic [1:0] dn;
        logic er, own, bwe, prev_clk;
        logic [DW-1:0] rdv, bdat;
        logic [AW-1:0] badr;
        int owners[8];
        int rise[8];
        int ng, nd, both, ndone;

        @(negedge i_clk);
        @(negedge i_clk);
        chk("reset_ctrl", {o_done, o_err, o_owner, o_busy, o_bus_clk, o_bus_we}, 0);
        chk("reset_rdata", o_rdata, 0);
        chk("reset_addr", o_bus_addr, 0);
        chk("reset_data", o_bus_data, 0);
        i_rst = 1'b0;
        tick();

        // CPU read, ready at the third strobe edge
        do_tx(0, 0, 32'h0000_1234, 32'h0, 32'hDEAD_BEEF, 3,
              hi, dn, er, rdv, own, bwe, badr, bdat);
        chk("rd_strobe_cycles", hi, 3);
        chk("rd_addr", badr, 32'h0000_1234);
        chk("rd_done", dn, 2'b01);
        chk("rd_rdata", rdv, 32'hDEAD_BEEF);
        chk("rd_err", er, 0);
        tick();

        // DMA write
        do_tx(1, 1, 32'h0000_2000, 32'h0000_0055, 32'hA5A5_A5A5, 2,
              hi, dn, er, rdv, own, bwe, badr, bdat);
        chk("wr_we", bwe, 1);
        chk("wr_data", bdat, 32'h55);
        chk("wr_owner", own, 1);
        chk("wr_done", dn, 2'b10);
        chk("wr_rdata", rdv, 0);
        tick();

        // Contention with immediate ready
        do_reset();
        i_addr0 = 32'h100; i_addr1 = 32'h200; i_we = 2'b00;
        i_req = 2'b11;
        ng = 0; nd = 0; both = 0; prev_clk = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (o_bus_clk && !prev_clk && ng < 8) begin
                owners[ng] = o_owner;
                rise[ng] = c;
                ng++;
            end
            if (o_done == 2'b11) both++;
            if (o_done != 2'b00) nd++;
            prev_clk = o_bus_clk;
            i_bus_data_ready = o_bus_clk;
            if (nd == 4) break;
        end
        i_req = 2'b00; i_bus_data_ready = 1'b0;
        chk("cont_dones", nd, 4);
        chk("cont_both_bits", both, 0);
        chk("cont_grants", ng >= 4, 1);
        for (int i = 0; i < 4 && i < ng; i++)
            chk("cont_owner", owners[i], i & 1);
        for (int i = 1; i < 4 && i < ng; i++)
            chk("cont_period", rise[i] - rise[i-1], 3);
        tick();

        // Timeout
        do_tx(0, 0, 32'h0000_3000, 32'h0, 32'h1234_5678, 0,
              hi, dn, er, rdv, own, bwe, badr, bdat);
        chk("to_strobe_cycles", hi, TO);
        chk("to_done", dn, 2'b01);
        chk("to_err", er, 1);
        chk("to_rdata", rdv, 0);
        tick();
        chk("to_idle_busy", o_busy, 0);

        // Async reset mid-strobe; leaves pointer favouring DMA unless reset
        i_we = 2'b00; i_addr0 = 32'h4000; i_req = 2'b01;
        tick();
        tick();
        chk("ar_pre_strobe", o_bus_clk, 1);
        #2 i_rst = 1'b1;
        #1;
        chk("ar_bus_clk", o_bus_clk, 0);
        chk("ar_done", o_done, 0);
        chk("ar_busy", o_busy, 0);
        i_req = 2'b11;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        chk("ar_grant_owner", o_owner, 0);
        chk("ar_grant_clk", o_bus_clk, 1);
        i_req = 2'b01;
        i_bus_data_ready = 1'b1;
        wait_done("ar_done_seen");
        i_req = 2'b00; i_bus_data_ready = 1'b0;
        tick();

        // Spurious ready while idle
        i_bus_data_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("sp_done", o_done, 0);
            chk("sp_busy", o_busy, 0);
        end
        i_bus_data_ready = 1'b0;

        // Random traffic
        ndone = 0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (o_done != 2'b00) ndone++;
            for (int p = 0; p < 2; p++) begin
                if (i_req[p]) begin
                    if (o_done[p]) i_req[p] = 1'b0;
                end else if ($urandom_range(3) == 0) begin
                    i_we[p] = 1'($urandom_range(1));
                    if (p == 0) begin
                        i_addr0 = $urandom; i_wdata0 = $urandom;
                    end else begin
                        i_addr1 = $urandom; i_wdata1 = $urandom;
                    end
                    i_req[p] = 1'b1;
                end
            end
            i_bus_data = $urandom;
            if (o_bus_clk)
                i_bus_data_ready = ($urandom_range(2) == 0);
            else
                i_bus_data_ready = 1'($urandom_range(1));
        end
        i_req = 2'b00; i_bus_data_ready = 1'b1;
        repeat (10) tick();
        chk("rand_progress", ndone >= 100, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
